// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - ALU function codes and response-buffer state encoding
package alu_share_pkg;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0110;
  localparam logic [3:0] FN_LUI = 4'b1011;

  // Compare/branch functions, selected with alt=1
  localparam logic [3:0] FN_EQ  = 4'b0001;
  localparam logic [3:0] FN_LT  = 4'b0010;
  localparam logic [3:0] FN_LTE = 4'b0011;
  localparam logic [3:0] FN_NE  = 4'b1001;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle ALU: arith/logic (alt=0) and signed compare (alt=1)
module alu
  import alu_share_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              alt,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] data,
  output logic              cond
);

  always_comb begin
    data = '0;
    cond = 1'b0;
    if (!alt) begin
      case (func)
        FN_ADD:  data = a + b;
        FN_SUB:  data = a - b;
        FN_AND:  data = a & b;
        FN_OR:   data = a | b;
        FN_XOR:  data = a ^ b;
        FN_LUI:  data = b << 16;
        default: data = '0;
      endcase
    end else begin
      case (func)
        FN_EQ:   cond = (a == b);
        FN_LT:   cond = ($signed(a) <  $signed(b));
        FN_LTE:  cond = ($signed(a) <= $signed(b));
        FN_NE:   cond = (a != b);
        default: cond = 1'b0;
      endcase
      // Compare results also appear as a 0/1 value on the data path
      data = {{(DATA_W-1){1'b0}}, cond};
    end
  end

endmodule

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - two-way round-robin grant; ties go to the requester not granted last
module alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any_req
);

  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) grant = ~last_grant;
    else if (valid1)      grant = 1'b1;
  end

  assign any_req = valid0 | valid1;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU between two requesters with a one-entry response buffer
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_alt,
  input  logic [3:0]        req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_alt,
  input  logic [3:0]        req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cond,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              busy
);

  rsp_state_e        state, state_nx;
  logic              last_grant, grant, any_req, can_accept, accept;
  logic              alu_alt, alu_cond;
  logic [3:0]        alu_func;
  logic [DATA_W-1:0] alu_a, alu_b, alu_data;
  logic [TAG_W-1:0]  sel_tag;

  alu_rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  // A full buffer can take a new op in the same cycle it drains
  assign can_accept = (state == ST_EMPTY) || (rsp_valid && rsp_ready);
  assign accept     = can_accept && any_req;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign rsp_valid  = (state == ST_FULL);
  assign busy       = rsp_valid || req0_valid || req1_valid;

  // grant is 0 when idle, so the ALU sees req0 then
  assign alu_alt  = grant ? req1_alt  : req0_alt;
  assign alu_func = grant ? req1_func : req0_func;
  assign alu_a    = grant ? req1_a    : req0_a;
  assign alu_b    = grant ? req1_b    : req0_b;
  assign sel_tag  = grant ? req1_tag  : req0_tag;

  alu #(.DATA_W(DATA_W)) u_alu (
    .alt  (alu_alt),
    .func (alu_func),
    .a    (alu_a),
    .b    (alu_b),
    .data (alu_data),
    .cond (alu_cond)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (accept) state_nx = ST_FULL;
      ST_FULL:  if (accept) state_nx = ST_FULL;
                else if (rsp_ready) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_data   <= '0;
      rsp_cond   <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rsp_id     <= grant;
        rsp_tag    <= sel_tag;
        rsp_data   <= alu_data;
        rsp_cond   <= alu_cond;
        last_grant <= grant;
        if (grant) cnt1 <= cnt1 + CNT_W'(1);
        else       cnt0 <= cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Time-multiplexes the existing single-cycle ALU between two requesters, e.g. the execute stage (req0) and a branch/compare helper (req1).
- Arbitrates round-robin and accepts one operation per cycle.
- Registers each ALU result, condition bit, requester id and tag into a one-entry response buffer drained by a valid/ready handshake.
- Sits between the decode/execute control and the ALU; the ALU itself is instantiated inside.

Parameters:
- DATA_W, 32, operand/result width (must match ALU).
- TAG_W, 4, opaque requester tag echoed with the response.
- CNT_W, 16, width of per-requester accepted-op counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_alt  in  1  ALU alternate-op select (0 arith/logic, 1 compare/branch).
- req0_func  in  4  ALU function code.
- req0_a  in  DATA_W  operand 1.
- req0_b  in  DATA_W  operand 2.
- req0_tag  in  TAG_W  tag.
- req1_valid, req1_ready, req1_alt, req1_func, req1_a, req1_b, req1_tag: same as req0, for requester 1.
- rsp_valid  out  1  response buffer full.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the op.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_data  out  DATA_W  ALU data result.
- rsp_cond  out  1  ALU branch/condition result.
- cnt0  out  CNT_W  ops accepted from req0.
- cnt1  out  CNT_W  ops accepted from req1.
- busy  out  1  rsp_valid OR any reqN_valid.

Behaviour:
- Reset (reset_n=0, takes effect immediately, no clock needed):
  - rsp_valid=0; rsp_id/rsp_tag/rsp_data/rsp_cond=0.
  - cnt0=cnt1=0; last_grant=1, so req0 wins the first tie.
  - FSM goes to EMPTY.
  - Any held response is discarded.
- FSM states and transitions:
  - EMPTY: response buffer empty. Moves to FULL on accept.
  - FULL: response buffer holds a result. Stays FULL if drain and accept happen in the same cycle. Moves to EMPTY if drain happens without accept.
- can_accept = (state==EMPTY) OR (rsp_valid AND rsp_ready). This allows full throughput: 1 op/cycle with rsp_ready held high.
- Grant, combinational:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = can_accept AND grant==N. At most one ready is high per cycle.
  - Ready may depend on the valids; requesters must not make valid depend on ready.
- Accept cycle:
  - The granted operands/alt/func drive the ALU combinationally.
  - At the clock edge: rsp_data, rsp_cond, rsp_id=N, rsp_tag are captured; rsp_valid=1; last_grant=N; cntN increments.
  - Latency from accept to rsp_valid is 1 cycle.
- Counters wrap modulo 2^CNT_W (0xFFFF+1 -> 0).
- Hold: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs stay stable and both reqN_ready=0.
- Idle: when no request is accepted, the ALU inputs are driven from req0 (don't-care). No register updates except the drain clearing rsp_valid.
- last_grant changes only on accept. A requester dropping valid without acceptance does not move priority.
- Width rules: the ALU result is taken as-is. Compare functions treat operands as signed; unknown func codes give data=0, cond=0.

Decomposition:
- Package alu_share_pkg holds:
  - ALU func constants: ADD=4'b0000, SUB=4'b0001, AND=4'b0100, OR=4'b0101, XOR=4'b0110, LUI=4'b1011; with alt=1: EQ=4'b0001, LT=4'b0010, LTE=4'b0011, NE=4'b1001.
  - FSM state encoding (EMPTY/FULL).
- One natural sub-module: alu_rr_arb2, the 2-way round-robin grant logic with a last_grant input.
- The existing ALU module is instantiated directly, not duplicated.

Test Plan:
1. After reset, req0 valid alt=0 func=0000 a=5 b=7 tag=3 -> req0_ready=1 same cycle; next cycle rsp_valid=1, data=12, cond=0, id=0, tag=3, cnt0=1.
2. Both valid in the same cycle: req0 SUB a=10 b=4, req1 alt=1 func=0010 a=0xFFFFFFFF b=0, rsp_ready=1 -> req0 granted first (data=6), req1 granted next cycle (data=1, cond=1, id=1).
3. Both valid continuously for 8 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1,0,1; cnt0=cnt1=4; one response per cycle.
4. Backpressure: rsp_ready=0 for 5 cycles with the buffer full -> both ready=0, rsp_* unchanged. On the cycle rsp_ready=1, a pending req1 is accepted, and rsp_valid stays 1 with the new data next cycle.
5. Edge ALU cases: alt=0 func=1011 b=0x00001234 -> data=0x12340000; alt=0 func=0010 -> data=0, cond=0; alt=1 func=1001 a=b=9 -> data=0, cond=0.
6. Reset mid-operation: drop reset_n while rsp_valid=1 and both reqs valid -> rsp_valid=0 and counters=0 without a clock edge. After release, the first tie is granted to req0.
